// File: rtl/counter_pkg.sv
// Shared types and constants for the modulo up/down counter (counter_mod).
package counter_pkg;
  typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_t;
  typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_t;
  localparam int CNT_MIN_WIDTH = 2;
endpackage

// File: rtl/counter_mod_next.sv
// Combinational next-count logic: range arithmetic for wrap and saturate modes.
module counter_mod_next
  import counter_pkg::*;
#(
  parameter int n = 8
) (
  input  logic [n-1:0] q,
  input  logic [n-1:0] limit,
  input  logic [n-1:0] step,
  input  cnt_dir_t     dir,
  input  cnt_mode_t    mode,
  output logic [n-1:0] next_q,
  output logic         wrap_next
);

  logic [n:0]   q_x, lim_x, step_x, span, sum;
  logic [n-1:0] up_wrap, dn_plain, dn_wrap;

  assign q_x    = {1'b0, q};
  assign lim_x  = {1'b0, limit};
  assign step_x = {1'b0, step};
  assign span   = lim_x + {{n{1'b0}}, 1'b1};
  assign sum    = q_x + step_x;

  // Each result below is known to lie in 0..limit when selected, so modulo-2^n
  // arithmetic on the low n bits gives the exact value.
  assign up_wrap  = sum[n-1:0] - span[n-1:0];
  assign dn_plain = q - step;
  assign dn_wrap  = q - step + span[n-1:0];

  always_comb begin
    next_q    = q;
    wrap_next = 1'b0;
    if (step_x == '0 || step_x > span) begin
      next_q = q;
    end else if (q_x > lim_x) begin
      if (dir == CNT_UP && mode == CNT_WRAP) begin
        next_q    = '0;
        wrap_next = 1'b1;
      end else begin
        next_q = limit;
      end
    end else if (dir == CNT_UP) begin
      if (sum <= lim_x) begin
        next_q = sum[n-1:0];
      end else if (mode == CNT_SAT) begin
        next_q = limit;
      end else begin
        next_q    = up_wrap;
        wrap_next = 1'b1;
      end
    end else begin
      if (step_x <= q_x) begin
        next_q = dn_plain;
      end else if (mode == CNT_SAT) begin
        next_q = '0;
      end else begin
        next_q    = dn_wrap;
        wrap_next = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_mod.sv
// Modulo up/down counter with programmable limit/step, wrap pulse and terminal count.
// Optional capture register enabled by defining COUNTER_MOD_CAPTURE_EN.
module counter_mod
  import counter_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic         up_down,
  input  logic         sat_mode,
  input  logic [n-1:0] r,
  input  logic [n-1:0] limit,
  input  logic [n-1:0] step,
  output logic [n-1:0] q,
  output logic         wrap,
  output logic         tc
`ifdef COUNTER_MOD_CAPTURE_EN
  ,
  input  logic         cap,
  output logic [n-1:0] cap_q
`endif
);

  logic [n-1:0] cnt_q, cnt_d, next_q;
  logic         wrap_q, wrap_d, wrap_next;

  counter_mod_next #(.n(n)) u_next (
    .q         (cnt_q),
    .limit     (limit),
    .step      (step),
    .dir       (cnt_dir_t'(up_down)),
    .mode      (cnt_mode_t'(sat_mode)),
    .next_q    (next_q),
    .wrap_next (wrap_next)
  );

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = r;
    end else if (en) begin
      cnt_d  = next_q;
      wrap_d = wrap_next;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef COUNTER_MOD_CAPTURE_EN
  logic [n-1:0] capv_q;

  // Captures the pre-update count, independent of load/en.
  always_ff @(posedge clk) begin
    if (clr) begin
      capv_q <= '0;
    end else if (cap) begin
      capv_q <= cnt_q;
    end
  end

  assign cap_q = capv_q;
`endif

  assign q    = cnt_q;
  assign wrap = wrap_q;
  assign tc   = up_down ? (cnt_q == limit) : (cnt_q == '0);

`ifndef SYNTHESIS
  logic [n:0] span_chk;
  assign span_chk = {1'b0, limit} + {{n{1'b0}}, 1'b1};

  illegal_step_a: assert property (@(posedge clk) disable iff (clr)
    (en && !load) |-> ({1'b0, step} <= span_chk));
`endif

endmodule
